// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, field positions, exception codes
// and helpers that pack the architectural SR/Cause words.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam int IM_HI  = 15;
  localparam int IM_LO  = 10;
  localparam int EXL    = 1;
  localparam int IE     = 0;
  localparam int BD     = 31;
  localparam int IP_HI  = 15;
  localparam int IP_LO  = 10;
  localparam int EXC_HI = 6;
  localparam int EXC_LO = 2;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w               = 32'h0000_0000;
    w[IM_HI:IM_LO]  = im;
    w[EXL]          = exl;
    w[IE]           = ie;
    return w;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] w;
    w                 = 32'h0000_0000;
    w[BD]             = bd;
    w[IP_HI:IP_LO]    = ip;
    w[EXC_HI:EXC_LO]  = exc;
    return w;
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor-0: exception/interrupt capture beside the M stage, SR/Cause/EPC
// state, mfc0/mtc0 access and the eret target.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc_in,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic        int_req
);

  logic [5:0]  r_sr_im;
  logic        r_sr_exl;
  logic        r_sr_ie;
  logic        r_cause_bd;
  logic [5:0]  r_cause_ip;
  logic [4:0]  r_cause_exc;
  logic [31:0] r_epc;

  logic        w_irq;
  logic        w_exc;
  logic        w_take;

  // Interrupt has priority over a synchronous exception in the same cycle.
  assign w_irq  = (|(hw_int & r_sr_im)) & r_sr_ie & ~r_sr_exl;
  assign w_exc  = (exc_code_in != 5'd0) & ~r_sr_exl;
  assign w_take = ~reset & (w_irq | w_exc);

  assign int_req = w_take;
  assign epc_out = r_epc;

  // CP0 state update: exception capture, mtc0 writes and eret.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr_im     <= 6'd0;
      r_sr_exl    <= 1'b0;
      r_sr_ie     <= 1'b0;
      r_cause_bd  <= 1'b0;
      r_cause_ip  <= 6'd0;
      r_cause_exc <= 5'd0;
      r_epc       <= 32'h0000_0000;
    end else begin
      r_cause_ip <= hw_int;
      if (w_take) begin
        r_sr_exl    <= 1'b1;
        r_cause_bd  <= bd_in;
        r_cause_exc <= w_irq ? EXC_INT : exc_code_in;
        r_epc       <= bd_in ? (pc_in - 32'd4) : pc_in;
      end else begin
        if (we) begin
          case (addr)
            REG_SR: begin
              r_sr_im  <= wdata[IM_HI:IM_LO];
              r_sr_exl <= wdata[EXL];
              r_sr_ie  <= wdata[IE];
            end
            REG_EPC: r_epc <= wdata;
            default: ;
          endcase
        end
        // Placed after the write so eret's EXL clear overrides an mtc0 to SR.
        if (eret) begin
          r_sr_exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux.
  always_comb begin
    rdata = 32'h0000_0000;
    case (addr)
      REG_SR:    rdata = pack_sr(r_sr_im, r_sr_exl, r_sr_ie);
      REG_CAUSE: rdata = pack_cause(r_cause_bd, r_cause_ip, r_cause_exc);
      REG_EPC:   rdata = r_epc;
      REG_PRID:  rdata = PRID_VALUE;
      default:   rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit.
module tb_cp0_unit;

  localparam logic [31:0] PRID = 32'h0001_8A05;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc_in;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        int_req;

  int errors = 0;
  int checks = 0;

  cp0_unit #(.PRID_VALUE(PRID)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .pc_in(pc_in), .bd_in(bd_in), .exc_code_in(exc_code_in), .eret(eret),
    .hw_int(hw_int), .rdata(rdata), .epc_out(epc_out), .int_req(int_req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; addr = 5'd0; wdata = 32'h0; pc_in = 32'h0;
    bd_in = 1'b0; exc_code_in = 5'd0; eret = 1'b0; hw_int = 6'h3F;
    tick(); tick();

    // Reset state
    rd(5'd12, "rst_sr", 32'h0000_0000);
    rd(5'd13, "rst_cause", 32'h0000_0000);
    rd(5'd14, "rst_epc", 32'h0000_0000);
    rd(5'd15, "rst_prid", PRID);
    check("rst_intreq", {31'd0, int_req}, 32'd0);

    reset = 1'b0; hw_int = 6'h00;
    tick();
    check("idle_intreq", {31'd0, int_req}, 32'd0);

    // mtc0 SR then enabled interrupt
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
    tick();
    we = 1'b0;
    rd(5'd12, "sr_written", 32'h0000_FC01);
    hw_int = 6'b000100; pc_in = 32'h0000_1000;
    #1;
    check("irq_intreq", {31'd0, int_req}, 32'd1);
    tick();
    check("irq_oneshot", {31'd0, int_req}, 32'd0);
    rd(5'd13, "irq_cause", 32'h0000_1000);
    rd(5'd14, "irq_epc", 32'h0000_1000);
    check("irq_epc_out", epc_out, 32'h0000_1000);
    rd(5'd12, "irq_sr", 32'h0000_FC03);

    hw_int = 6'b000000; eret = 1'b1;
    tick();
    eret = 1'b0;
    rd(5'd12, "eret_sr", 32'h0000_FC01);

    // Exception in delay slot
    exc_code_in = 5'd12; bd_in = 1'b1; pc_in = 32'h0000_3010;
    #1;
    check("ov_intreq", {31'd0, int_req}, 32'd1);
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    rd(5'd14, "ov_epc", 32'h0000_300C);
    rd(5'd13, "ov_cause", 32'h8000_0030);
    rd(5'd12, "ov_sr", 32'h0000_FC03);

    // Masked while EXL
    exc_code_in = 5'd10; hw_int = 6'b000001;
    #1;
    check("masked_intreq", {31'd0, int_req}, 32'd0);
    tick();
    exc_code_in = 5'd0;
    rd(5'd13, "masked_cause", 32'h8000_0430);
    rd(5'd14, "masked_epc", 32'h0000_300C);
    eret = 1'b1;
    #1;
    check("eret_cycle_intreq", {31'd0, int_req}, 32'd0);
    tick();
    eret = 1'b0;
    rd(5'd12, "eret2_sr", 32'h0000_FC01);
    check("reassert_intreq", {31'd0, int_req}, 32'd1);

    // Interrupt beats syscall, simultaneous mtc0 EPC ignored
    pc_in = 32'h0000_4000; exc_code_in = 5'd8;
    we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEC;
    tick();
    we = 1'b0; exc_code_in = 5'd0;
    rd(5'd13, "irqwin_cause", 32'h0000_0400);
    rd(5'd14, "irqwin_epc", 32'h0000_4000);
    rd(5'd12, "irqwin_sr", 32'h0000_FC03);

    // Cause is read-only, SR masks unwritable bits
    we = 1'b1; addr = 5'd13; wdata = 32'hFFFF_FFFF;
    tick();
    addr = 5'd12;
    tick();
    we = 1'b0;
    rd(5'd13, "cause_ro", 32'h0000_0400);
    rd(5'd12, "sr_mask", 32'h0000_FC03);

    // eret and mtc0 SR together: eret owns EXL
    eret = 1'b1; we = 1'b1; addr = 5'd12; wdata = 32'h0000_0003;
    tick();
    eret = 1'b0; we = 1'b0;
    rd(5'd12, "eret_we_sr", 32'h0000_0001);
    check("im_off_intreq", {31'd0, int_req}, 32'd0);

    // mtc0 EPC, unmapped addresses
    we = 1'b1; addr = 5'd14; wdata = 32'hDEAD_BEEC;
    tick();
    addr = 5'd5; wdata = 32'h1234_5678;
    tick();
    we = 1'b0;
    check("mtc0_epc_out", epc_out, 32'hDEAD_BEEC);
    rd(5'd5, "unmapped_rd", 32'h0000_0000);
    rd(5'd16, "unmapped16_rd", 32'h0000_0000);

    // pc_in - 4 wraps
    exc_code_in = 5'd4; bd_in = 1'b1; pc_in = 32'h0000_0000;
    tick();
    exc_code_in = 5'd0; bd_in = 1'b0;
    rd(5'd14, "wrap_epc", 32'hFFFF_FFFC);
    rd(5'd13, "wrap_cause", 32'h8000_0410);

    // Reset mid-handler
    reset = 1'b1;
    tick();
    rd(5'd12, "midrst_sr", 32'h0000_0000);
    rd(5'd14, "midrst_epc", 32'h0000_0000);

    // int_req gated by reset even when SR would allow an interrupt
    reset = 1'b0; hw_int = 6'd0;
    we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
    tick();
    we = 1'b0; hw_int = 6'b100000; reset = 1'b1;
    #1;
    check("rst_gate_intreq", {31'd0, int_req}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_intreq", {31'd0, int_req}, 32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
